// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into 32-bit instruction words and
// writes them into the instruction-RAM window. It also holds the CPU in reset
// until a complete program has been loaded.
module imem_loader #(
  parameter logic [23:0] BASE_ADDRESS = 24'd0,
  parameter int          MAX_WORDS    = 64,
  parameter bit          BIG_ENDIAN   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [6:0]  i_word_count,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output logic        o_mem_we,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_cpu_hold
);

  localparam logic [6:0] MAX_W = 7'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_byte_cnt;
  logic [6:0]  r_word_idx;
  logic [6:0]  r_count;
  logic [31:0] r_shift;
  logic        r_rx_ready, r_mem_we, r_busy, r_done, r_error, r_cpu_hold;
  logic [31:0] r_mem_addr, r_mem_data;

  logic        w_count_ok;
  logic        w_xfer;
  logic        w_last_word;
  logic [31:0] w_shift;

  // A start is only honoured for a count inside 1..MAX_WORDS.
  assign w_count_ok  = (i_word_count != 7'd0) && (i_word_count <= MAX_W);
  // r_rx_ready is high exactly while in RECV, so this is the byte handshake.
  assign w_xfer      = (r_state == S_RECV) && i_rx_valid && r_rx_ready;
  assign w_last_word = (r_word_idx == (r_count - 7'd1));
  // First byte lands in the top byte (big endian) or bottom byte (little).
  assign w_shift     = BIG_ENDIAN ? {r_shift[23:0], i_rx_data}
                                  : {i_rx_data, r_shift[31:8]};

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start && w_count_ok) w_next = S_RECV;
      S_RECV:  if (w_xfer && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_DONE : S_RECV;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; status outputs follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte_cnt <= 2'd0;
      r_word_idx <= 7'd0;
      r_count    <= 7'd0;
      r_shift    <= 32'd0;
      r_rx_ready <= 1'b0;
      r_mem_addr <= 32'd0;
      r_mem_data <= 32'd0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_rx_ready <= (w_next == S_RECV);
      r_mem_we   <= (w_next == S_WRITE);
      r_busy     <= (w_next == S_RECV) || (w_next == S_WRITE);
      r_done     <= (w_next == S_DONE);

      if ((r_state == S_IDLE) && i_start) begin
        if (w_count_ok) begin
          r_count    <= i_word_count;
          r_word_idx <= 7'd0;
          r_byte_cnt <= 2'd0;
          r_cpu_hold <= 1'b1;
          r_error    <= 1'b0;
        end else begin
          r_error    <= 1'b1;
        end
      end

      if (w_xfer) begin
        r_shift    <= w_shift;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_mem_data <= w_shift;
          r_mem_addr <= {BASE_ADDRESS, r_word_idx[5:0], 2'b00};
        end
      end

      if (r_state == S_WRITE) r_word_idx <= r_word_idx + 7'd1;

      if (w_next == S_DONE) r_cpu_hold <= 1'b0;
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_mem_we   = r_mem_we;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_cpu_hold = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued when a load
// is issued and popped by a monitor whenever the DUT strobes mem_we.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, rxv, rdy, we, busy, done, err, hold;
  logic [6:0]  wc;
  logic [7:0]  rxd;
  logic [31:0] addr, data;

  logic        p_start, p_rxv, p_rdy, p_we, p_busy, p_done, p_err, p_hold;
  logic [6:0]  p_wc;
  logic [7:0]  p_rxd;
  logic [31:0] p_addr, p_data;

  imem_loader u_dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_word_count(wc),
    .i_rx_data(rxd), .i_rx_valid(rxv), .o_rx_ready(rdy), .o_mem_addr(addr),
    .o_mem_data(data), .o_mem_we(we), .o_busy(busy), .o_done(done),
    .o_error(err), .o_cpu_hold(hold)
  );

  imem_loader #(.BASE_ADDRESS(24'h000001), .MAX_WORDS(64), .BIG_ENDIAN(1'b0)) u_dut_p (
    .i_clk(clk), .i_reset(rst), .i_start(p_start), .i_word_count(p_wc),
    .i_rx_data(p_rxd), .i_rx_valid(p_rxv), .o_rx_ready(p_rdy), .o_mem_addr(p_addr),
    .o_mem_data(p_data), .o_mem_we(p_we), .o_busy(p_busy), .o_done(p_done),
    .o_error(p_err), .o_cpu_hold(p_hold)
  );

  int          n_chk = 0, n_pass = 0, n_we = 0, n_done = 0;
  logic [63:0] sb[$];
  logic [7:0]  bq[$];
  logic [63:0] mon_e;
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Monitor: every write must match the head of the scoreboard; done must
  // directly follow a write.
  always @(negedge clk) begin
    if (rst) prev_we = 1'b0;
    else begin
      if (we) begin
        n_we++;
        check("rdy_in_write", 32'(rdy), 32'd0);
        if (sb.size() == 0) check("unexp_write", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("addr", addr, mon_e[63:32]);
          check("data", data, mon_e[31:0]);
        end
      end
      if (done) begin
        n_done++;
        check("done_after_we", 32'(prev_we), 32'd1);
        check("hold_at_done", 32'(hold), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
      end
      prev_we = we;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rxv = 1'b1; rxd = b;
    while (!rdy && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("rx_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    check("done_seen", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  // Issue a load of cnt words from bq (big endian expectation).
  task automatic load(input int cnt, input bit gaps, input bit mid);
    int w0 = n_we;
    for (int i = 0; i < cnt; i++)
      sb.push_back({32'(i * 4), bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]});
    start = 1'b1; wc = 7'(cnt);
    @(negedge clk);
    start = 1'b0;
    check("hold_in_load", 32'(hold), 32'd1);
    for (int i = 0; i < bq.size(); i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin rxv = 1'b0; @(negedge clk); end
      end
      if (mid && i == 5) begin
        rxv = 1'b0; start = 1'b1; wc = 7'd3;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(bq[i]);
    end
    rxv = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("we_count", 32'(n_we - w0), 32'(cnt));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("hold_after", 32'(hold), 32'd0);
  endtask

  task automatic bad_start(input logic [6:0] c);
    int w0 = n_we;
    start = 1'b1; wc = c;
    @(negedge clk);
    start = 1'b0;
    check("err_set", 32'(err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("err_rdy", 32'(rdy), 32'd0);
      @(negedge clk);
    end
    check("err_busy", 32'(busy), 32'd0);
    check("err_no_we", 32'(n_we - w0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pb [4];
    start = 0; wc = 0; rxd = 0; rxv = 0;
    p_start = 0; p_wc = 0; p_rxd = 0; p_rxv = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_rdy",  32'(rdy),  32'd0);
    check("rst_addr", addr,      32'd0);
    check("rst_data", data,      32'd0);
    check("rst_we",   32'(we),   32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_hold", 32'(hold), 32'd1);
    repeat (10) @(negedge clk);
    check("idle_no_we", 32'(n_we), 32'd0);

    // Little-endian instance with a non-zero base, exact latency
    pb = '{8'h0A, 8'h00, 8'h02, 8'h18};
    p_start = 1'b1; p_wc = 7'd1;
    @(negedge clk);
    p_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p_rxv = 1'b1; p_rxd = pb[i];
      @(negedge clk);
    end
    p_rxv = 1'b0;
    check("p_we",   32'(p_we), 32'd1);
    check("p_addr", p_addr,    32'h0000_0100);
    check("p_data", p_data,    32'h1802_000A);
    @(negedge clk);
    check("p_done", 32'(p_done), 32'd1);

    // Two-word load, back to back
    bq = '{8'h18, 8'h02, 8'h00, 8'h0A, 8'h90, 8'h42, 8'h50, 8'h00};
    load(2, 1'b0, 1'b0);

    // Same data with random gaps and a start pulse mid-load
    load(2, 1'b1, 1'b1);

    // Full-window load
    bq.delete();
    for (int i = 0; i < 256; i++) bq.push_back(8'($urandom));
    load(64, 1'b0, 1'b0);

    // Invalid counts
    bad_start(7'd0);
    bad_start(7'd65);

    // Reset in the middle of word 0, then a fresh single-word load
    start = 1'b1; wc = 7'd1;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared", 32'(err), 32'd0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rxv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_hold", 32'(hold), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we",   32'(we),   32'd0);
    bq = '{8'h00, 8'h00, 8'h00, 8'h00};
    load(1, 1'b0, 1'b0);
    rxv = 1'b1; rxd = 8'h0A;
    for (int k = 0; k < 4; k++) begin
      check("rdy_after_done", 32'(rdy), 32'd0);
      @(negedge clk);
    end
    rxv = 1'b0;
    repeat (3) @(negedge clk);
    check("done_total", 32'(n_done), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
